// File: rtl/data_upload_if.sv
// -----------------------------------------------------------------------------
// data_upload_if
// Bundles the SPI pins and the core RAM read port of the upload engine.
//   SPI side : sck, ss, sdi (controller -> engine), sdo (engine -> controller)
//   Window   : base, length (sampled by the engine at upload start)
//   RAM read : rd, a (engine -> RAM), din, din_valid (RAM -> engine)
//   Status   : uploading, count, underrun (engine -> core)
// The slave modport is the upload engine; the master modport is its
// environment (IO controller plus core RAM).
// -----------------------------------------------------------------------------
interface data_upload_if;
    logic        sck;
    logic        ss;
    logic        sdi;
    logic        sdo;
    logic [24:0] base;
    logic [24:0] length;
    logic        uploading;
    logic        rd;
    logic [24:0] a;
    logic [7:0]  din;
    logic        din_valid;
    logic [24:0] count;
    logic        underrun;

    modport slave (
        input  sck, ss, sdi, base, length, din, din_valid,
        output sdo, uploading, rd, a, count, underrun
    );

    modport master (
        output sck, ss, sdi, base, length, din, din_valid,
        input  sdo, uploading, rd, a, count, underrun
    );
endinterface

// File: rtl/data_upload.sv
// -----------------------------------------------------------------------------
// data_upload
// SPI-slave file read-back engine. After a start command the IO controller
// clocks bytes out of a core RAM window. Bytes are prefetched one ahead via a
// rd / din_valid handshake and shifted out MSB-first on sdo. SPI pins are
// oversampled in the clk domain; nothing is clocked by sck.
// Ports:
//   clk    - system clock, the only clock
//   reset  - asynchronous, active-high; clears all state
//   bus    - data_upload_if.slave: SPI pins, RAM read port, status outputs
// Commands (first byte of a frame):
//   CMD_RX     - control byte follows; LSB 1 = start upload, 0 = end upload
//   CMD_RX_DAT - data frame; every following byte slot carries one upload byte
// -----------------------------------------------------------------------------
module data_upload #(
    parameter logic [7:0] CMD_RX     = 8'h56,
    parameter logic [7:0] CMD_RX_DAT = 8'h57,
    parameter logic [7:0] FILL       = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    data_upload_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    // sck: two sync flops, a third stage and one history flop for edge detect
    logic [3:0]  sck_pipe_reg;
    logic [1:0]  ss_pipe_reg;
    logic [1:0]  sdi_pipe_reg;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  cmd_reg;
    logic [7:0]  tx_reg;
    logic [7:0]  pbuf_reg;
    logic [7:0]  cur_reg;
    logic [24:0] ptr_reg;
    logic [24:0] remaining_reg;
    logic [24:0] count_reg;
    logic [24:0] a_reg;
    logic        sdo_reg;
    logic        uploading_reg;
    logic        rd_reg;
    logic        underrun_reg;
    logic        inflight_reg;
    logic [2:0]  drop_reg;

    logic        ss_s;
    logic        sdi_s;
    logic        rise;
    logic        fall;
    logic        ctrl_rise;
    logic        start_cmd;
    logic        end_cmd;
    logic        consume;
    logic        commit;
    logic        drop_rsp;
    logic        abandon;
    logic [7:0]  load_byte;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_pipe_reg <= '0;
            ss_pipe_reg  <= '1;
            sdi_pipe_reg <= '0;
        end else begin
            sck_pipe_reg <= {sck_pipe_reg[2:0], bus.sck};
            ss_pipe_reg  <= {ss_pipe_reg[0], bus.ss};
            sdi_pipe_reg <= {sdi_pipe_reg[0], bus.sdi};
        end
    end

    assign ss_s  = ss_pipe_reg[1];
    assign sdi_s = sdi_pipe_reg[1];
    assign rise  = sck_pipe_reg[2] & ~sck_pipe_reg[3];
    assign fall  = ~sck_pipe_reg[2] & sck_pipe_reg[3];

    // ---------------------------------------------------------------- decode
    // Start/end is decided on the last rise of the control byte; consume is
    // decided on the fall that opens a data byte, so the two never coincide.
    assign ctrl_rise = rise && !ss_s && (cnt_reg == 5'd15) && (cmd_reg == CMD_RX);
    assign start_cmd = ctrl_rise && sdi_s;
    assign end_cmd   = ctrl_rise && !sdi_s;
    assign consume   = fall && !ss_s && (cnt_reg == 5'd8) &&
                       (cmd_reg == CMD_RX_DAT) && uploading_reg;
    // A byte only counts once its last bit has been clocked by the controller.
    assign commit    = rise && !ss_s && (cnt_reg == 5'd15) &&
                       (cmd_reg == CMD_RX_DAT) && inflight_reg;

    // Responses to abandoned fetches are swallowed in arrival order so that a
    // stale din_valid can never land in pbuf of a later request.
    assign drop_rsp  = bus.din_valid && (drop_reg != 3'd0);
    assign abandon   = (start_cmd || end_cmd) && (state_reg == WAIT) &&
                       !(bus.din_valid && (drop_reg == 3'd0));

    // Byte presented at the start of each data slot. An unfinished byte (frame
    // aborted by ss, or the trailing fall at frame end) is replayed first, so
    // the next data frame resumes exactly where the controller stopped.
    always_comb begin
        load_byte = 8'h00;
        if ((cmd_reg == CMD_RX_DAT) && uploading_reg) begin
            if (inflight_reg) begin
                load_byte = cur_reg;
            end else if (remaining_reg == 25'd0) begin
                load_byte = 8'h00;
            end else if (state_reg == FULL) begin
                load_byte = pbuf_reg;
            end else begin
                load_byte = FILL;
            end
        end
    end

    // ---------------------------------------------------------------- engine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            cmd_reg       <= '0;
            tx_reg        <= '0;
            pbuf_reg      <= '0;
            cur_reg       <= '0;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            count_reg     <= '0;
            a_reg         <= '0;
            sdo_reg       <= 1'b0;
            uploading_reg <= 1'b0;
            rd_reg        <= 1'b0;
            underrun_reg  <= 1'b0;
            inflight_reg  <= 1'b0;
            drop_reg      <= '0;
        end else begin
            // ---- SPI bit engine
            if (ss_s) begin
                cnt_reg <= '0;
                sdo_reg <= 1'b0;
            end else begin
                if (rise) begin
                    cnt_reg <= (cnt_reg == 5'd15) ? 5'd8 : cnt_reg + 5'd1;
                    if (cnt_reg < 5'd8) begin
                        shift_reg <= {shift_reg[6:0], sdi_s};
                        if (cnt_reg == 5'd7) begin
                            cmd_reg <= {shift_reg[6:0], sdi_s};
                        end
                    end
                end
                if (fall) begin
                    if (cnt_reg == 5'd8) begin
                        sdo_reg <= load_byte[7];
                        tx_reg  <= {load_byte[6:0], 1'b0};
                    end else begin
                        sdo_reg <= tx_reg[7];
                        tx_reg  <= {tx_reg[6:0], 1'b0};
                    end
                end
            end

            // ---- prefetch FSM
            rd_reg   <= 1'b0;
            drop_reg <= drop_reg - {2'b00, drop_rsp} + {2'b00, abandon};
            case (state_reg)
                IDLE: ;
                REQ: begin
                    rd_reg    <= 1'b1;
                    a_reg     <= ptr_reg;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (bus.din_valid && (drop_reg == 3'd0)) begin
                        pbuf_reg  <= bus.din;
                        state_reg <= FULL;
                    end
                end
                FULL: ;
                default: state_reg <= IDLE;
            endcase

            // ---- consume at the opening fall of a data byte
            if (consume && !inflight_reg && (remaining_reg != 25'd0)) begin
                if (state_reg == FULL) begin
                    cur_reg       <= pbuf_reg;
                    ptr_reg       <= ptr_reg + 25'd1;
                    remaining_reg <= remaining_reg - 25'd1;
                    inflight_reg  <= 1'b1;
                    state_reg     <= (remaining_reg != 25'd1) ? REQ : IDLE;
                end else begin
                    underrun_reg  <= 1'b1;
                end
            end

            if (commit) begin
                count_reg    <= count_reg + 25'd1;
                inflight_reg <= 1'b0;
            end

            // ---- control commands override any fetch in progress
            if (start_cmd) begin
                ptr_reg       <= bus.base;
                remaining_reg <= bus.length;
                count_reg     <= '0;
                underrun_reg  <= 1'b0;
                uploading_reg <= 1'b1;
                inflight_reg  <= 1'b0;
                rd_reg        <= 1'b0;
                state_reg     <= (bus.length != 25'd0) ? REQ : IDLE;
            end
            if (end_cmd) begin
                uploading_reg <= 1'b0;
                inflight_reg  <= 1'b0;
                rd_reg        <= 1'b0;
                state_reg     <= IDLE;
            end
        end
    end

    assign bus.sdo       = sdo_reg;
    assign bus.uploading = uploading_reg;
    assign bus.rd        = rd_reg;
    assign bus.a         = a_reg;
    assign bus.count     = count_reg;
    assign bus.underrun  = underrun_reg;
endmodule

// File: tb/tb_data_upload.sv
// -----------------------------------------------------------------------------
// tb_data_upload
// Directed bench for data_upload: drives SPI frames as the IO controller,
// models the core RAM with a programmable in-order read latency, and checks
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_upload;
    localparam int HALF = 6;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_upload_if bus();

    data_upload dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ RAM model
    logic [7:0]  mem [logic [24:0]];
    logic [24:0] req_addr_q[$];
    int          req_due_q[$];
    logic [24:0] rd_log[$];
    int          cyc      = 0;
    int          ram_lat  = 2;
    int          last_due = 0;

    always @(negedge clk) begin : ram_model
        int due;
        cyc = cyc + 1;
        bus.din_valid = 1'b0;
        if (req_due_q.size() != 0 && req_due_q[0] <= cyc) begin
            bus.din = mem.exists(req_addr_q[0]) ? mem[req_addr_q[0]] : 8'hEE;
            bus.din_valid = 1'b1;
            void'(req_addr_q.pop_front());
            void'(req_due_q.pop_front());
        end
        if (bus.rd === 1'b1) begin
            rd_log.push_back(bus.a);
            due = cyc + ram_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            req_addr_q.push_back(bus.a);
            req_due_q.push_back(due);
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic s);
        bus.sdi = b;
        repeat (HALF) @(negedge clk);
        s = bus.sdo;
        bus.sck = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.sck = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] dat,
                            input int nbits, output logic [63:0] rx);
        logic s;
        rx = '0;
        bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(dat[7 - (i % 8)], s);
            rx = {rx[62:0], s};
        end
        repeat (HALF) @(negedge clk);
        bus.ss = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic start_upload(input logic [24:0] b, input logic [24:0] len);
        logic [63:0] rx;
        bus.base   = b;
        bus.length = len;
        rd_log.delete();
        spi_xfer(8'h56, 8'h01, 8, rx);
    endtask

    task automatic wait_ram_idle();
        int n = 0;
        while (req_due_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ram_drain", 64'(req_due_q.size()), 64'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [63:0] rx;
        logic        s;
        bus.sck = 1'b0; bus.ss = 1'b1; bus.sdi = 1'b0;
        bus.base = '0;  bus.length = '0;
        mem[25'h100000] = 8'h11; mem[25'h100001] = 8'h22; mem[25'h100002] = 8'h33;
        mem[25'h000300] = 8'hA5; mem[25'h000301] = 8'h5A;
        mem[25'h000400] = 8'hC1; mem[25'h000401] = 8'hC2; mem[25'h000402] = 8'hC3;
        mem[25'h1FFFFFF] = 8'h77; mem[25'h0000000] = 8'h88;
        mem[25'h000600] = 8'h9C; mem[25'h000700] = 8'h3E;
        mem[25'h000800] = 8'hF0; mem[25'h000801] = 8'hF1;
        mem[25'h000900] = 8'h4B;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_sdo",       64'(bus.sdo),       64'd0);
        chk("rst_uploading", 64'(bus.uploading), 64'd0);
        chk("rst_rd",        64'(bus.rd),        64'd0);
        chk("rst_a",         64'(bus.a),         64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_underrun",  64'(bus.underrun),  64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // basic 3-byte upload read by a 5-byte frame
        start_upload(25'h100000, 25'd3);
        chk("t1_uploading", 64'(bus.uploading), 64'd1);
        spi_xfer(8'h57, 8'h00, 40, rx);
        chk("t1_data",     rx[39:0] , 64'h11_22_33_00_00);
        chk("t1_count",    64'(bus.count), 64'd3);
        chk("t1_rd_num",   64'(rd_log.size()), 64'd3);
        chk("t1_rd_addr0", 64'(rd_log[0]), 64'h100000);
        chk("t1_rd_addr2", 64'(rd_log[2]), 64'h100002);
        chk("t1_underrun", 64'(bus.underrun), 64'd0);

        // slow RAM on the second byte -> FILL, then correct data
        start_upload(25'h000300, 25'd2);
        ram_lat = 150;
        spi_xfer(8'h57, 8'h00, 24, rx);
        ram_lat = 2;
        chk("t2_data",     rx[23:0], 64'hA5_FF_5A);
        chk("t2_underrun", 64'(bus.underrun), 64'd1);
        chk("t2_count",    64'(bus.count), 64'd2);
        chk("t2_rd_num",   64'(rd_log.size()), 64'd2);
        chk("t2_rd_addr1", 64'(rd_log[1]), 64'h000301);

        // ss abort after 3 bits of the second byte, then resume
        start_upload(25'h000400, 25'd3);
        spi_xfer(8'h57, 8'h00, 11, rx);
        chk("t3_partial",  rx[10:0], {53'd0, 8'hC1, 3'b110});
        chk("t3_count_ab", 64'(bus.count), 64'd1);
        spi_xfer(8'h57, 8'h00, 16, rx);
        chk("t3_resume",   rx[15:0], 64'hC2_C3);
        chk("t3_count",    64'(bus.count), 64'd3);
        chk("t3_rd_num",   64'(rd_log.size()), 64'd3);

        // 25-bit address wrap
        start_upload(25'h1FFFFFF, 25'd2);
        spi_xfer(8'h57, 8'h00, 16, rx);
        chk("t4_data",     rx[15:0], 64'h77_88);
        chk("t4_rd_addr0", 64'(rd_log[0]), 64'h1FFFFFF);
        chk("t4_rd_addr1", 64'(rd_log[1]), 64'h0000000);

        // end command while waiting for RAM
        ram_lat = 400;
        start_upload(25'h000500, 25'd4);
        chk("t5_rd_num0",   64'(rd_log.size()), 64'd1);
        spi_xfer(8'h56, 8'h00, 8, rx);
        chk("t5_uploading", 64'(bus.uploading), 64'd0);
        wait_ram_idle();
        spi_xfer(8'h57, 8'h00, 8, rx);
        chk("t5_data",      rx[7:0], 64'h00);
        chk("t5_rd_num1",   64'(rd_log.size()), 64'd1);

        // restart while a fetch is outstanding: stale response discarded
        ram_lat = 300;
        start_upload(25'h000700, 25'd1);
        ram_lat = 2;
        start_upload(25'h000600, 25'd1);
        wait_ram_idle();
        spi_xfer(8'h57, 8'h00, 8, rx);
        chk("t6_data",  rx[7:0], 64'h9C);
        chk("t6_count", 64'(bus.count), 64'd1);

        // asynchronous reset in the middle of a byte
        start_upload(25'h000800, 25'd2);
        bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(((8'h57 >> i) & 8'h01) != 8'h00, s);
        rx = '0;
        for (int i = 0; i < 11; i++) begin
            spi_bit(1'b0, s);
            rx = {rx[62:0], s};
        end
        chk("t7_first",     rx[10:0], {53'd0, 8'hF0, 3'b111});
        chk("t7_pre_count", 64'(bus.count), 64'd1);
        chk("t7_pre_sdo",   64'(bus.sdo), 64'd1);
        chk("t7_pre_a",     64'(bus.a), 64'h000801);
        #2 reset = 1'b1;
        #1;
        chk("t7_rst_sdo",       64'(bus.sdo),       64'd0);
        chk("t7_rst_uploading", 64'(bus.uploading), 64'd0);
        chk("t7_rst_count",     64'(bus.count),     64'd0);
        chk("t7_rst_a",         64'(bus.a),         64'd0);
        chk("t7_rst_rd",        64'(bus.rd),        64'd0);
        @(negedge clk);
        bus.ss = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        start_upload(25'h000900, 25'd1);
        spi_xfer(8'h57, 8'h00, 8, rx);
        chk("t7_after_data",     rx[7:0], 64'h4B);
        chk("t7_after_count",    64'(bus.count), 64'd1);
        chk("t7_after_underrun", 64'(bus.underrun), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
